// File: rtl/vx_mem_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory channel among NUM_REQS requesters.
// Optional transaction timeout with error response: define VX_MEM_ARB_TIMEOUT_EN.
module vx_mem_arbiter #(
    parameter int unsigned NUM_REQS     = 2,
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned ADDR_WIDTH   = 26,
    parameter int unsigned TAG_WIDTH    = 56,
    parameter int unsigned BYTEEN_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned IDX_WIDTH    = (NUM_REQS > 2) ? $clog2(NUM_REQS) : 1
`ifdef VX_MEM_ARB_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQS-1:0]              up_req_valid,
    input  logic [NUM_REQS-1:0]              up_req_rw,
    input  logic [NUM_REQS*BYTEEN_WIDTH-1:0] up_req_byteen,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]   up_req_addr,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]   up_req_data,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]    up_req_tag,
    output logic [NUM_REQS-1:0]              up_req_ready,
    output logic [NUM_REQS-1:0]              up_rsp_valid,
    output logic [DATA_WIDTH-1:0]            up_rsp_data,
    output logic [TAG_WIDTH-1:0]             up_rsp_tag,
    input  logic [NUM_REQS-1:0]              up_rsp_ready,
    output logic                             dn_req_valid,
    output logic                             dn_req_rw,
    output logic [BYTEEN_WIDTH-1:0]          dn_req_byteen,
    output logic [ADDR_WIDTH-1:0]            dn_req_addr,
    output logic [DATA_WIDTH-1:0]            dn_req_data,
    output logic [TAG_WIDTH-1:0]             dn_req_tag,
    input  logic                             dn_req_ready,
    input  logic                             dn_rsp_valid,
    input  logic [DATA_WIDTH-1:0]            dn_rsp_data,
    input  logic [TAG_WIDTH-1:0]             dn_rsp_tag,
    output logic                             dn_rsp_ready,
    output logic                             busy,
    output logic [IDX_WIDTH-1:0]             owner
`ifdef VX_MEM_ARB_TIMEOUT_EN
    , output logic                           timeout_err
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP
    } state_t;

    state_t                  state;
    logic [IDX_WIDTH-1:0]    rr_ptr;
    logic                    req_rw_q;
    logic [BYTEEN_WIDTH-1:0] req_byteen_q;
    logic [ADDR_WIDTH-1:0]   req_addr_q;
    logic [DATA_WIDTH-1:0]   req_data_q;
    logic [TAG_WIDTH-1:0]    req_tag_q;

    logic                    found;
    logic [IDX_WIDTH-1:0]    winner;
    logic [IDX_WIDTH-1:0]    cand;
    logic                    rsp_done;
    logic                    tmo_hit;

    // Search starts one past the last owner and wraps at NUM_REQS, not at 2**IDX_WIDTH.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = rr_ptr;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            cand = (cand == IDX_WIDTH'(NUM_REQS - 1)) ? '0 : cand + 1'b1;
            if (!found && up_req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign rsp_done = (state == WAIT_RSP) && dn_rsp_valid && up_rsp_ready[owner];

`ifdef VX_MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_WIDTH-1:0] tmo_cnt;

    // Held at zero in IDLE, so it is zero on the first ISSUE cycle.
    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit     = (state != IDLE) && !rsp_done
                         && (tmo_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    assign timeout_err = tmo_hit;
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= IDX_WIDTH'(NUM_REQS - 1);
            owner        <= '0;
            req_rw_q     <= 1'b0;
            req_byteen_q <= '0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            req_tag_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner        <= winner;
                        req_rw_q     <= up_req_rw[winner];
                        req_byteen_q <= up_req_byteen[winner*BYTEEN_WIDTH +: BYTEEN_WIDTH];
                        req_addr_q   <= up_req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
                        req_data_q   <= up_req_data[winner*DATA_WIDTH +: DATA_WIDTH];
                        req_tag_q    <= up_req_tag[winner*TAG_WIDTH +: TAG_WIDTH];
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (dn_req_ready) begin
                        state <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (rsp_done) begin
                        rr_ptr <= owner;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (tmo_hit) begin
                rr_ptr <= owner;
                state  <= IDLE;
            end
        end
    end

    always_comb begin
        up_req_ready = '0;
        if (state == IDLE && found) begin
            up_req_ready[winner] = 1'b1;
        end
        up_rsp_valid = '0;
        if (state == WAIT_RSP) begin
            up_rsp_valid[owner] = dn_rsp_valid;
        end
        if (tmo_hit) begin
            up_rsp_valid[owner] = 1'b1;
        end
    end

    assign up_rsp_data   = tmo_hit ? '1 : dn_rsp_data;
    assign up_rsp_tag    = tmo_hit ? req_tag_q : dn_rsp_tag;
    assign dn_rsp_ready  = (state == WAIT_RSP) && up_rsp_ready[owner];

    assign dn_req_valid  = (state == ISSUE);
    assign dn_req_rw     = req_rw_q;
    assign dn_req_byteen = req_byteen_q;
    assign dn_req_addr   = req_addr_q;
    assign dn_req_data   = req_data_q;
    assign dn_req_tag    = req_tag_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_vx_mem_arbiter.sv
// Scoreboard bench for vx_mem_arbiter: three requesters, narrow data path, default build.
module tb_vx_mem_arbiter;

    localparam int NR = 3;
    localparam int DW = 64;
    localparam int AW = 26;
    localparam int TW = 16;
    localparam int BW = 8;
    localparam int IW = 2;
    localparam logic [NR-1:0] ONE = 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    up_req_valid, up_req_rw, up_req_ready, up_rsp_valid, up_rsp_ready;
    logic [NR*BW-1:0] up_req_byteen;
    logic [NR*AW-1:0] up_req_addr;
    logic [NR*DW-1:0] up_req_data;
    logic [NR*TW-1:0] up_req_tag;
    logic [DW-1:0]    up_rsp_data;
    logic [TW-1:0]    up_rsp_tag;
    logic             dn_req_valid, dn_req_rw, dn_req_ready;
    logic [BW-1:0]    dn_req_byteen;
    logic [AW-1:0]    dn_req_addr;
    logic [DW-1:0]    dn_req_data;
    logic [TW-1:0]    dn_req_tag;
    logic             dn_rsp_valid, dn_rsp_ready;
    logic [DW-1:0]    dn_rsp_data;
    logic [TW-1:0]    dn_rsp_tag;
    logic             busy;
    logic [IW-1:0]    owner;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic          rw;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } req_t;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    req_t cur[NR];
    int   n_checks = 0;
    int   n_fail   = 0;

    vx_mem_arbiter #(
        .NUM_REQS  (NR),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TAG_WIDTH (TW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .up_req_valid (up_req_valid),
        .up_req_rw    (up_req_rw),
        .up_req_byteen(up_req_byteen),
        .up_req_addr  (up_req_addr),
        .up_req_data  (up_req_data),
        .up_req_tag   (up_req_tag),
        .up_req_ready (up_req_ready),
        .up_rsp_valid (up_rsp_valid),
        .up_rsp_data  (up_rsp_data),
        .up_rsp_tag   (up_rsp_tag),
        .up_rsp_ready (up_rsp_ready),
        .dn_req_valid (dn_req_valid),
        .dn_req_rw    (dn_req_rw),
        .dn_req_byteen(dn_req_byteen),
        .dn_req_addr  (dn_req_addr),
        .dn_req_data  (dn_req_data),
        .dn_req_tag   (dn_req_tag),
        .dn_req_ready (dn_req_ready),
        .dn_rsp_valid (dn_rsp_valid),
        .dn_rsp_data  (dn_rsp_data),
        .dn_rsp_tag   (dn_rsp_tag),
        .dn_rsp_ready (dn_rsp_ready),
        .busy         (busy),
        .owner        (owner)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic req_t mk_req(input int i, input logic rw, input logic [BW-1:0] be,
                                    input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                    input logic [TW-1:0] tag);
        req_t r;
        r.idx = IW'(i); r.rw = rw; r.be = be; r.addr = addr; r.data = data; r.tag = tag;
        return r;
    endfunction

    task automatic set_req(input int i, input req_t r);
        cur[i]                     = r;
        up_req_valid[i]            = 1'b1;
        up_req_rw[i]               = r.rw;
        up_req_byteen[i*BW +: BW]  = r.be;
        up_req_addr[i*AW +: AW]    = r.addr;
        up_req_data[i*DW +: DW]    = r.data;
        up_req_tag[i*TW +: TW]     = r.tag;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        up_req_valid = '0; up_req_rw = '0; up_req_byteen = '0; up_req_addr = '0;
        up_req_data = '0; up_req_tag = '0; up_rsp_ready = '0;
        dn_req_ready = 1'b0; dn_rsp_valid = 1'b0; dn_rsp_data = '0; dn_rsp_tag = '0;
        req_q.delete(); rsp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        #1;
        if (|up_req_ready) begin ok = 1'b1; return; end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            if (|up_req_ready) begin ok = 1'b1; return; end
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_checks++; if (owner !== '0) begin n_fail++; $display("FAIL reset_owner: got %0d, expected 0", owner); end
        n_checks++; if (dn_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dn_req_valid: got %b, expected 0", dn_req_valid); end
        n_checks++; if (up_req_ready !== '0) begin n_fail++; $display("FAIL reset_up_req_ready: got %b, expected 000", up_req_ready); end
        n_checks++; if (up_rsp_valid !== '0) begin n_fail++; $display("FAIL reset_up_rsp_valid: got %b, expected 000", up_rsp_valid); end
        n_checks++; if (dn_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL reset_dn_rsp_ready: got %b, expected 0", dn_rsp_ready); end
    endtask

    task automatic test_single_read();
        bit ok; req_t e; rsp_t r;
        do_reset();
        set_req(0, mk_req(0, 1'b0, 8'hFF, 26'h0000010, 64'h0, 16'h005A));
        req_q.push_back(cur[0]);
        up_rsp_ready = '1; dn_req_ready = 1'b1;
        wait_grant(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_grant_wait: got no grant, expected grant within 8 cycles"); end
        e = req_q.pop_front();
        n_checks++; if (up_req_ready !== 3'b001) begin n_fail++; $display("FAIL single_grant: got %b, expected 001", up_req_ready); end
        @(negedge clk); up_req_valid[0] = 1'b0; #1;
        n_checks++; if (dn_req_valid !== 1'b1) begin n_fail++; $display("FAIL single_dn_valid: got %b, expected 1", dn_req_valid); end
        n_checks++; if (dn_req_addr !== e.addr) begin n_fail++; $display("FAIL single_dn_addr: got %h, expected %h", dn_req_addr, e.addr); end
        n_checks++; if (dn_req_tag !== e.tag) begin n_fail++; $display("FAIL single_dn_tag: got %h, expected %h", dn_req_tag, e.tag); end
        n_checks++; if ({busy, owner} !== {1'b1, e.idx}) begin n_fail++; $display("FAIL single_busy_owner: got %b/%0d, expected 1/%0d", busy, owner, e.idx); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_checks++; if (up_rsp_valid !== '0) begin n_fail++; $display("FAIL single_no_early_rsp: got %b, expected 000", up_rsp_valid); end
        end
        @(negedge clk);
        dn_rsp_valid = 1'b1; dn_rsp_data = 64'hDEAD_BEEF_0BAD_F00D; dn_rsp_tag = dn_req_tag;
        rsp_q.push_back('{idx: e.idx, data: 64'hDEAD_BEEF_0BAD_F00D, tag: e.tag});
        #1;
        r = rsp_q.pop_front();
        n_checks++; if (up_rsp_valid !== (ONE << r.idx)) begin n_fail++; $display("FAIL single_rsp_valid: got %b, expected %b", up_rsp_valid, ONE << r.idx); end
        n_checks++; if (up_rsp_data !== r.data) begin n_fail++; $display("FAIL single_rsp_data: got %h, expected %h", up_rsp_data, r.data); end
        n_checks++; if (up_rsp_tag !== r.tag) begin n_fail++; $display("FAIL single_rsp_tag: got %h, expected %h", up_rsp_tag, r.tag); end
        n_checks++; if (dn_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL single_dn_rsp_ready: got %b, expected 1", dn_rsp_ready); end
        @(negedge clk); dn_rsp_valid = 1'b0; #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b, expected 0", busy); end
    endtask

    task automatic test_contention(input logic [NR-1:0] mask, input int e0, input int e1,
                                   input int e2, input int e3);
        bit ok; req_t e; rsp_t r; req_t nr; logic [TW-1:0] dtag; logic [DW-1:0] rdata;
        int order[4];
        order = '{e0, e1, e2, e3};
        do_reset();
        for (int i = 0; i < NR; i++) begin
            if (mask[i]) set_req(i, mk_req(i, i[0], BW'(8'h0F << i), AW'(32'h100 * (i + 1)),
                                           64'hA5A5_0000_0000_0000 | DW'(i), TW'(32'h1000 * (i + 1))));
        end
        dn_req_ready = 1'b1; up_rsp_ready = '1;
        for (int k = 0; k < 4; k++) begin
            req_q.push_back(cur[order[k]]);
            wait_grant(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL cont_grant_wait: got no grant, expected grant in txn %0d", k); end
            e = req_q.pop_front();
            n_checks++; if (up_req_ready !== (ONE << e.idx)) begin n_fail++; $display("FAIL cont_grant: txn %0d got %b, expected %b", k, up_req_ready, ONE << e.idx); end
            @(negedge clk);
            nr = cur[e.idx]; nr.addr = nr.addr + 1'b1; nr.tag = nr.tag + 1'b1; nr.data = ~nr.data;
            set_req(int'(e.idx), nr);
            #1;
            n_checks++; if ({dn_req_valid, dn_req_rw, dn_req_byteen, dn_req_addr, dn_req_data, dn_req_tag} !== {1'b1, e.rw, e.be, e.addr, e.data, e.tag}) begin
                n_fail++; $display("FAIL cont_dn_req: txn %0d got %b %b %h %h %h %h, expected 1 %b %h %h %h %h", k, dn_req_valid, dn_req_rw, dn_req_byteen, dn_req_addr, dn_req_data, dn_req_tag, e.rw, e.be, e.addr, e.data, e.tag);
            end
            dtag = dn_req_tag;
            @(negedge clk);
            rdata = 64'hC0DE_0000_0000_0000 | DW'(k);
            dn_rsp_valid = 1'b1; dn_rsp_data = rdata; dn_rsp_tag = dtag;
            rsp_q.push_back('{idx: e.idx, data: rdata, tag: e.tag});
            #1;
            r = rsp_q.pop_front();
            n_checks++; if ({up_rsp_valid, up_rsp_data, up_rsp_tag, owner} !== {ONE << r.idx, r.data, r.tag, r.idx}) begin
                n_fail++; $display("FAIL cont_rsp: txn %0d got %b %h %h owner %0d, expected %b %h %h owner %0d", k, up_rsp_valid, up_rsp_data, up_rsp_tag, owner, ONE << r.idx, r.data, r.tag, r.idx);
            end
            @(negedge clk); dn_rsp_valid = 1'b0;
        end
        up_req_valid = '0;
    endtask

    task automatic test_backpressure();
        bit ok; req_t e; rsp_t r;
        do_reset();
        set_req(2, mk_req(2, 1'b1, 8'hA5, 26'h2ABCDE, 64'h0123_4567_89AB_CDEF, 16'h2222));
        req_q.push_back(cur[2]);
        up_rsp_ready = '1;
        wait_grant(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_grant_wait: got no grant, expected grant within 8 cycles"); end
        e = req_q.pop_front();
        n_checks++; if (up_req_ready !== 3'b100) begin n_fail++; $display("FAIL bp_grant: got %b, expected 100", up_req_ready); end
        @(negedge clk);
        up_req_valid[2] = 1'b0;
        set_req(0, mk_req(0, 1'b0, 8'h01, 26'h33, 64'h1, 16'h0033));
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if ({dn_req_valid, dn_req_rw, dn_req_byteen, dn_req_addr, dn_req_data, dn_req_tag} !== {1'b1, e.rw, e.be, e.addr, e.data, e.tag}) begin
                n_fail++; $display("FAIL bp_dn_stable: cycle %0d got %b %b %h %h %h %h", c, dn_req_valid, dn_req_rw, dn_req_byteen, dn_req_addr, dn_req_data, dn_req_tag);
            end
            n_checks++; if (up_req_ready !== '0) begin n_fail++; $display("FAIL bp_no_grant: cycle %0d got %b, expected 000", c, up_req_ready); end
            @(negedge clk);
        end
        dn_req_ready = 1'b1;
        @(negedge clk);
        dn_req_ready = 1'b0;
        dn_rsp_valid = 1'b1; dn_rsp_data = 64'h5555_AAAA_5555_AAAA; dn_rsp_tag = 16'hFFFF;
        up_rsp_ready = 3'b011;
        rsp_q.push_back('{idx: e.idx, data: 64'h5555_AAAA_5555_AAAA, tag: 16'hFFFF});
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if ({dn_rsp_ready, up_rsp_valid, busy, dn_req_valid} !== {1'b0, 3'b100, 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL bp_rsp_hold: cycle %0d got rdy %b vld %b busy %b dnv %b, expected 0 100 1 0", c, dn_rsp_ready, up_rsp_valid, busy, dn_req_valid);
            end
            @(negedge clk);
        end
        up_rsp_ready = '1;
        #1;
        r = rsp_q.pop_front();
        n_checks++; if ({dn_rsp_ready, up_rsp_valid, up_rsp_data, up_rsp_tag} !== {1'b1, ONE << r.idx, r.data, r.tag}) begin
            n_fail++; $display("FAIL bp_rsp_release: got %b %b %h %h, expected 1 %b %h %h", dn_rsp_ready, up_rsp_valid, up_rsp_data, up_rsp_tag, ONE << r.idx, r.data, r.tag);
        end
        @(negedge clk); dn_rsp_valid = 1'b0; #1;
        n_checks++; if ({busy, up_req_ready} !== {1'b0, 3'b001}) begin n_fail++; $display("FAIL bp_next_grant: got busy %b ready %b, expected 0 001", busy, up_req_ready); end
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        do_reset();
        set_req(1, mk_req(1, 1'b0, 8'hF0, 26'h77, 64'h0, 16'h0777));
        dn_req_ready = 1'b1; up_rsp_ready = '1;
        wait_grant(ok);
        n_checks++; if (!ok || up_req_ready !== 3'b010) begin n_fail++; $display("FAIL rst_grant: got %b, expected 010", up_req_ready); end
        @(negedge clk); up_req_valid[1] = 1'b0;
        @(negedge clk); #1;
        n_checks++; if ({busy, dn_req_valid} !== 2'b10) begin n_fail++; $display("FAIL rst_in_wait: got busy %b dnv %b, expected 1 0", busy, dn_req_valid); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_req(0, mk_req(0, 1'b0, 8'h01, 26'h1, 64'h0, 16'h0001));
        set_req(1, mk_req(1, 1'b0, 8'h02, 26'h2, 64'h0, 16'h0002));
        dn_rsp_valid = 1'b1; dn_rsp_data = '1; dn_rsp_tag = 16'h0777;
        #1;
        n_checks++; if (up_rsp_valid !== '0) begin n_fail++; $display("FAIL rst_late_rsp: got %b, expected 000", up_rsp_valid); end
        n_checks++; if ({busy, dn_rsp_ready} !== 2'b00) begin n_fail++; $display("FAIL rst_idle: got busy %b rdy %b, expected 0 0", busy, dn_rsp_ready); end
        n_checks++; if (up_req_ready !== 3'b001) begin n_fail++; $display("FAIL rst_next_grant: got %b, expected 001", up_req_ready); end
        @(negedge clk); dn_rsp_valid = 1'b0; up_req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention(3'b011, 0, 1, 0, 1);
        test_contention(3'b111, 0, 1, 2, 0);
        test_backpressure();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_mem_arbiter.md
Name: vx_mem_arbiter

Overview:
- Round-robin arbiter that shares one Vortex-style memory request/response channel among NUM_REQS requesters.
- Sits between several Vortex memory clients (e.g. core bank, DMA/debug port) and the single-outstanding AHB bridge adapter downstream.
- Allows exactly one transaction in flight, because the downstream adapter is single-outstanding.
- Latches the winning request, issues it downstream, waits for the response and returns it to the owning requester.

Parameters:
- NUM_REQS, 2: number of upstream requesters (2..8).
- DATA_WIDTH, 512: request/response data width.
- ADDR_WIDTH, 26: line address width (DATA_WIDTH/8-byte lines).
- TAG_WIDTH, 56: tag width, passed through unmodified.
- BYTEEN_WIDTH, DATA_WIDTH/8: byte-enable width.
- IDX_WIDTH, max(1,$clog2(NUM_REQS)): width of requester index.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- up_req_valid  in  NUM_REQS  per-requester request valid.
- up_req_rw  in  NUM_REQS  per-requester write(1)/read(0).
- up_req_byteen  in  NUM_REQS*BYTEEN_WIDTH  flattened byte enables; requester i at slice i.
- up_req_addr  in  NUM_REQS*ADDR_WIDTH  flattened line addresses.
- up_req_data  in  NUM_REQS*DATA_WIDTH  flattened write data.
- up_req_tag  in  NUM_REQS*TAG_WIDTH  flattened tags.
- up_req_ready  out  NUM_REQS  one-hot accept.
- up_rsp_valid  out  NUM_REQS  one-hot response valid.
- up_rsp_data  out  DATA_WIDTH  response data, broadcast to all requesters.
- up_rsp_tag  out  TAG_WIDTH  response tag, broadcast to all requesters.
- up_rsp_ready  in  NUM_REQS  per-requester response ready.
- dn_req_valid / dn_req_rw / dn_req_byteen / dn_req_addr / dn_req_data / dn_req_tag  out  1/1/BYTEEN_WIDTH/ADDR_WIDTH/DATA_WIDTH/TAG_WIDTH  downstream request.
- dn_req_ready  in  1  downstream accept.
- dn_rsp_valid  in  1  downstream response valid.
- dn_rsp_data  in  DATA_WIDTH  downstream response data.
- dn_rsp_tag  in  TAG_WIDTH  downstream response tag.
- dn_rsp_ready  out  1  downstream response ready.
- busy  out  1  high whenever state != IDLE.
- owner  out  IDX_WIDTH  index of the current or last granted requester.

Behaviour:
- Reset values: state=IDLE, rr_ptr=NUM_REQS-1, owner=0, all latched request fields 0, every output valid/ready 0, busy 0.
- Reset asserted mid-transaction aborts it: no response is forwarded, and any late dn_rsp_valid after reset is ignored (dn_rsp_ready=0 in IDLE).
- States:
  - IDLE: if any up_req_valid, select the winner by round-robin, searching from rr_ptr+1 mod NUM_REQS upward with wrap.
    - up_req_ready[winner]=1 combinationally in this cycle; all other readies are 0.
    - Latch the winner's rw/byteen/addr/data/tag and set owner=winner.
    - Next state ISSUE.
    - If no valid, stay in IDLE with all readies 0.
  - ISSUE: dn_req_valid=1 with the latched fields, held stable until dn_req_ready. On dn_req_valid && dn_req_ready -> WAIT_RSP.
  - WAIT_RSP: dn_rsp_ready=up_rsp_ready[owner]; up_rsp_valid[owner]=dn_rsp_valid; up_rsp_data/up_rsp_tag = dn_rsp_data/dn_rsp_tag.
    - On handshake (dn_rsp_valid && up_rsp_ready[owner]): rr_ptr<=owner, next state IDLE.
- Responses are returned for writes as well as reads; the downstream channel always responds.
- Latency: request accepted in cycle T; dn_req_valid asserted from T+1; response forwarded in the same cycle it arrives (combinational pass-through).
- Minimum arbitration-to-arbitration period: 3 cycles (IDLE, ISSUE, WAIT_RSP).
- Fairness: a requester that holds valid is granted within NUM_REQS transactions.
- A single active requester is re-granted every transaction.
- up_req_valid dropping while not granted has no effect; arbitration is re-evaluated every IDLE cycle.
- up_rsp_valid is never asserted to a non-owner. Upstream tags are not checked.

Optional Feature:
- Macro: VX_MEM_ARB_TIMEOUT_EN.
- With the macro defined:
  - Adds parameter TIMEOUT_CYCLES (default 1024) and output port timeout_err (1 bit).
  - A counter clears on entry to ISSUE and increments each cycle spent in ISSUE or WAIT_RSP.
  - When the counter reaches TIMEOUT_CYCLES-1 without the completing handshake:
    - timeout_err pulses for 1 cycle.
    - The FSM returns to IDLE with rr_ptr<=owner.
    - An error response is returned to the owner: up_rsp_valid[owner] pulses in that cycle with up_rsp_data all-ones and up_rsp_tag = latched tag, regardless of up_rsp_ready.
- Without the macro: no counter and no timeout_err port; the FSM waits indefinitely.

Test Plan:
- Single read: req0 valid, addr=0x0000010, tag=0x5A; dn_req_ready=1; dn_rsp_valid 4 cycles later with data=0xDEAD...; up_rsp_ready0=1 -> up_req_ready0 at T, dn_req_addr=0x10 at T+1, up_rsp_valid[0] carries data/tag 0x5A, busy falls the next cycle.
- Contention, NUM_REQS=2: both valid continuously for 4 transactions -> grant order 0,1,0,1; owner matches each response.
- Downstream backpressure: dn_req_ready held 0 for 5 cycles -> dn_req_* stable for all 5 cycles, no new grants.
- Upstream response backpressure: up_rsp_ready[owner]=0 for 3 cycles -> dn_rsp_ready=0 for those cycles, state stays WAIT_RSP, non-owner up_rsp_valid=0.
- Reset in WAIT_RSP: assert reset 1 cycle, then dn_rsp_valid=1 -> no up_rsp_valid, busy=0, next grant goes to requester 0.
- (VX_MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): no dn_rsp ever -> timeout_err pulses 16 cycles after entering ISSUE; up_rsp_valid[owner] pulses with all-ones data; the arbiter then grants the next requester.
